// File: rtl/alu_reservation_station.sv
// alu_reservation_station: four-entry ALU reservation station with writeback wakeup and in-order-by-index issue
module alu_reservation_station #(
  parameter int DATA_LEN  = 32,
  parameter int RRF_SEL   = 6,
  parameter int ALU_OP_W  = 4,
  parameter int ENTRY_NUM = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                kill_i,
  input  logic                dispatch_valid_i,
  output logic                dispatch_ready_o,
  input  logic [ALU_OP_W-1:0] dispatch_alu_op_i,
  input  logic [RRF_SEL-1:0]  dispatch_dst_tag_i,
  input  logic [DATA_LEN-1:0] dispatch_src1_i,
  input  logic [DATA_LEN-1:0] dispatch_src2_i,
  input  logic                dispatch_rdy1_i,
  input  logic                dispatch_rdy2_i,
  input  logic                wb0_valid_i,
  input  logic [RRF_SEL-1:0]  wb0_tag_i,
  input  logic [DATA_LEN-1:0] wb0_data_i,
  input  logic                wb1_valid_i,
  input  logic [RRF_SEL-1:0]  wb1_tag_i,
  input  logic [DATA_LEN-1:0] wb1_data_i,
  output logic                issue_valid_o,
  input  logic                issue_ready_i,
  output logic [ALU_OP_W-1:0] issue_alu_op_o,
  output logic [RRF_SEL-1:0]  issue_dst_tag_o,
  output logic [DATA_LEN-1:0] issue_src1_o,
  output logic [DATA_LEN-1:0] issue_src2_o,
  output logic [2:0]          count_o
);
  logic [ENTRY_NUM-1:0]                     valid_q, valid_d;
  logic [ENTRY_NUM-1:0][ALU_OP_W-1:0]       op_q, op_d;
  logic [ENTRY_NUM-1:0][RRF_SEL-1:0]        dst_q, dst_d;
  logic [ENTRY_NUM-1:0][1:0][DATA_LEN-1:0]  src_q, src_d;
  logic [ENTRY_NUM-1:0][1:0]                rdy_q, rdy_d;
  logic [ENTRY_NUM-1:0][1:0]                w0, w1;
  logic [1:0][DATA_LEN-1:0]                 dsrc;
  logic [1:0]                               drdy, dw0, dw1;
  logic [ENTRY_NUM-1:0]                     ready_vec;
  logic [1:0]                               sel, free;
  logic                                     accept, fire;

  assign dsrc = {dispatch_src2_i, dispatch_src1_i};
  assign drdy = {dispatch_rdy2_i, dispatch_rdy1_i};
  assign dispatch_ready_o = ~&valid_q;
  assign accept = dispatch_valid_i && dispatch_ready_o && !kill_i;
  assign issue_valid_o = |ready_vec;
  assign fire = issue_valid_o && issue_ready_i && !kill_i;
  assign issue_alu_op_o  = issue_valid_o ? op_q[sel] : '0;
  assign issue_dst_tag_o = issue_valid_o ? dst_q[sel] : '0;
  assign issue_src1_o    = issue_valid_o ? src_q[sel][0] : '0;
  assign issue_src2_o    = issue_valid_o ? src_q[sel][1] : '0;

  // broadcast tag matches for waiting entry sources and for the operands being dispatched
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++)
      for (int j = 0; j < 2; j++) begin
        w0[i][j] = valid_q[i] && !rdy_q[i][j] && wb0_valid_i && src_q[i][j][RRF_SEL-1:0] == wb0_tag_i;
        w1[i][j] = valid_q[i] && !rdy_q[i][j] && wb1_valid_i && src_q[i][j][RRF_SEL-1:0] == wb1_tag_i;
      end
    for (int j = 0; j < 2; j++) begin
      dw0[j] = !drdy[j] && wb0_valid_i && dsrc[j][RRF_SEL-1:0] == wb0_tag_i;
      dw1[j] = !drdy[j] && wb1_valid_i && dsrc[j][RRF_SEL-1:0] == wb1_tag_i;
    end
  end

  // lowest-index fully ready entry for issue and lowest-index free entry for dispatch
  always_comb begin
    sel = '0;
    free = '0;
    for (int i = 0; i < ENTRY_NUM; i++) ready_vec[i] = valid_q[i] && rdy_q[i][0] && rdy_q[i][1];
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      sel = ready_vec[i] ? 2'(i) : sel;
      free = !valid_q[i] ? 2'(i) : free;
    end
  end

  // occupancy is the population count of registered valid bits
  always_comb begin
    count_o = '0;
    for (int i = 0; i < ENTRY_NUM; i++) count_o = count_o + 3'(valid_q[i]);
  end

  // next entry state: wakeup, issue clear, dispatch write with bypass, kill flush
  always_comb begin
    valid_d = valid_q;
    op_d = op_q;
    dst_d = dst_q;
    src_d = src_q;
    rdy_d = rdy_q;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      for (int j = 0; j < 2; j++) begin
        src_d[i][j] = w0[i][j] ? wb0_data_i : w1[i][j] ? wb1_data_i : src_q[i][j];
        rdy_d[i][j] = rdy_q[i][j] | w0[i][j] | w1[i][j];
      end
      if (fire && sel == 2'(i)) valid_d[i] = 1'b0;
      if (accept && free == 2'(i)) begin
        valid_d[i] = 1'b1;
        op_d[i] = dispatch_alu_op_i;
        dst_d[i] = dispatch_dst_tag_i;
        for (int j = 0; j < 2; j++) begin
          src_d[i][j] = dw0[j] ? wb0_data_i : dw1[j] ? wb1_data_i : dsrc[j];
          rdy_d[i][j] = drdy[j] | dw0[j] | dw1[j];
        end
      end
    end
    if (kill_i) valid_d = '0;
  end

  // entry storage; reset clears every field
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      op_q <= '0;
      dst_q <= '0;
      src_q <= '0;
      rdy_q <= '0;
    end else begin
      valid_q <= valid_d;
      op_q <= op_d;
      dst_q <= dst_d;
      src_q <= src_d;
      rdy_q <= rdy_d;
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed scoreboard bench for the ALU reservation station
module tb_alu_reservation_station;
  typedef logic [73:0] rec_t;
  logic        clk_i = 0;
  logic        reset_i, kill_i, dispatch_valid_i, dispatch_ready_o;
  logic [3:0]  dispatch_alu_op_i;
  logic [5:0]  dispatch_dst_tag_i;
  logic [31:0] dispatch_src1_i, dispatch_src2_i;
  logic        dispatch_rdy1_i, dispatch_rdy2_i;
  logic        wb0_valid_i, wb1_valid_i;
  logic [5:0]  wb0_tag_i, wb1_tag_i;
  logic [31:0] wb0_data_i, wb1_data_i;
  logic        issue_valid_o, issue_ready_i;
  logic [3:0]  issue_alu_op_o;
  logic [5:0]  issue_dst_tag_o;
  logic [31:0] issue_src1_o, issue_src2_o;
  logic [2:0]  count_o;
  int checks = 0;
  int errors = 0;
  rec_t exp_q[$];

  alu_reservation_station dut (
    .clk_i(clk_i), .reset_i(reset_i), .kill_i(kill_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
    .dispatch_alu_op_i(dispatch_alu_op_i), .dispatch_dst_tag_i(dispatch_dst_tag_i),
    .dispatch_src1_i(dispatch_src1_i), .dispatch_src2_i(dispatch_src2_i),
    .dispatch_rdy1_i(dispatch_rdy1_i), .dispatch_rdy2_i(dispatch_rdy2_i),
    .wb0_valid_i(wb0_valid_i), .wb0_tag_i(wb0_tag_i), .wb0_data_i(wb0_data_i),
    .wb1_valid_i(wb1_valid_i), .wb1_tag_i(wb1_tag_i), .wb1_data_i(wb1_data_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_alu_op_o(issue_alu_op_o), .issue_dst_tag_o(issue_dst_tag_o),
    .issue_src1_o(issue_src1_o), .issue_src2_o(issue_src2_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // monitor: every accepted issue must match the next expected record
  always @(negedge clk_i) begin
    if (issue_valid_o && issue_ready_i && !kill_i && !reset_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected got op=%h dst=%h s1=%h s2=%h", issue_alu_op_o, issue_dst_tag_o, issue_src1_o, issue_src2_o);
      end else if ({issue_alu_op_o, issue_dst_tag_o, issue_src1_o, issue_src2_o} !== exp_q[0]) begin
        errors++;
        $display("FAIL issue_data got %h expected %h", {issue_alu_op_o, issue_dst_tag_o, issue_src1_o, issue_src2_o}, exp_q[0]);
        void'(exp_q.pop_front());
      end else void'(exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [5:0] dst, input logic [31:0] a, input logic ra, input logic [31:0] b, input logic rb);
    dispatch_valid_i = 1;
    dispatch_alu_op_i = op;
    dispatch_dst_tag_i = dst;
    dispatch_src1_i = a;
    dispatch_rdy1_i = ra;
    dispatch_src2_i = b;
    dispatch_rdy2_i = rb;
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] dst, input logic [31:0] a, input logic ra, input logic [31:0] b, input logic rb);
    set_disp(op, dst, a, ra, b, rb);
    step();
    dispatch_valid_i = 0;
  endtask

  initial begin
    reset_i = 1; kill_i = 0; dispatch_valid_i = 0; issue_ready_i = 0;
    dispatch_alu_op_i = 0; dispatch_dst_tag_i = 0; dispatch_src1_i = 0; dispatch_src2_i = 0;
    dispatch_rdy1_i = 0; dispatch_rdy2_i = 0;
    wb0_valid_i = 0; wb0_tag_i = 0; wb0_data_i = 0; wb1_valid_i = 0; wb1_tag_i = 0; wb1_data_i = 0;
    step(); step();
    reset_i = 0;
    chk("rst_issue_valid", 32'(issue_valid_o), 0);
    chk("rst_issue_src1", issue_src1_o, 0);
    chk("rst_dispatch_ready", 32'(dispatch_ready_o), 1);
    chk("rst_count", 32'(count_o), 0);
    // basic ready dispatch issues next cycle
    issue_ready_i = 1;
    exp_q.push_back({4'd3, 6'd5, 32'h2, 32'h7});
    disp(3, 5, 32'h2, 1, 32'h7, 1);
    chk("basic_issue_valid", 32'(issue_valid_o), 1);
    chk("basic_count", 32'(count_o), 1);
    step();
    chk("basic_count_after", 32'(count_o), 0);
    chk("basic_issue_valid_after", 32'(issue_valid_o), 0);
    // wakeup via wb0
    disp(1, 2, 32'h1, 0, 32'h10, 1);
    chk("wake_wait_valid", 32'(issue_valid_o), 0);
    chk("wake_wait_count", 32'(count_o), 1);
    step();
    wb0_valid_i = 1; wb0_tag_i = 1; wb0_data_i = 32'h2;
    exp_q.push_back({4'd1, 6'd2, 32'h2, 32'h10});
    step();
    wb0_valid_i = 0;
    chk("wake_issue_valid", 32'(issue_valid_o), 1);
    chk("wake_issue_src1", issue_src1_o, 32'h2);
    step();
    chk("wake_count_after", 32'(count_o), 0);
    // dispatch-time bypass from wb1
    wb1_valid_i = 1; wb1_tag_i = 9; wb1_data_i = 32'hAB;
    exp_q.push_back({4'd2, 6'd3, 32'hAB, 32'h5});
    disp(2, 3, 32'h9, 0, 32'h5, 1);
    wb1_valid_i = 0;
    chk("bypass_issue_valid", 32'(issue_valid_o), 1);
    chk("bypass_issue_src1", issue_src1_o, 32'hAB);
    step();
    // fill, backpressure, single issue, refill
    issue_ready_i = 0;
    exp_q.push_back({4'd4, 6'd10, 32'h40, 32'h41});
    exp_q.push_back({4'd8, 6'd14, 32'h55, 32'h66});
    exp_q.push_back({4'd5, 6'd11, 32'h50, 32'h51});
    exp_q.push_back({4'd6, 6'd12, 32'h60, 32'h61});
    exp_q.push_back({4'd7, 6'd13, 32'h70, 32'h71});
    disp(4, 10, 32'h40, 1, 32'h41, 1);
    disp(5, 11, 32'h50, 1, 32'h51, 1);
    disp(6, 12, 32'h60, 1, 32'h61, 1);
    disp(7, 13, 32'h70, 1, 32'h71, 1);
    chk("full_count", 32'(count_o), 4);
    chk("full_dispatch_ready", 32'(dispatch_ready_o), 0);
    set_disp(8, 14, 32'h55, 1, 32'h66, 1);
    step();
    chk("full_hold_count", 32'(count_o), 4);
    issue_ready_i = 1;
    step();
    issue_ready_i = 0;
    chk("full_after_issue_count", 32'(count_o), 3);
    chk("full_after_issue_ready", 32'(dispatch_ready_o), 1);
    step();
    dispatch_valid_i = 0;
    chk("refill_count", 32'(count_o), 4);
    issue_ready_i = 1;
    repeat (4) step();
    chk("drain_count", 32'(count_o), 0);
    // out-of-order readiness: entries 0 and 2 issue before waiting entry 1
    issue_ready_i = 0;
    exp_q.push_back({4'd1, 6'd20, 32'hA0, 32'hA1});
    exp_q.push_back({4'd3, 6'd22, 32'hC0, 32'hC1});
    exp_q.push_back({4'd2, 6'd21, 32'h77, 32'hB1});
    disp(1, 20, 32'hA0, 1, 32'hA1, 1);
    disp(2, 21, 32'd20, 0, 32'hB1, 1);
    disp(3, 22, 32'hC0, 1, 32'hC1, 1);
    issue_ready_i = 1;
    step(); step();
    chk("ooo_wait_valid", 32'(issue_valid_o), 0);
    chk("ooo_wait_count", 32'(count_o), 1);
    wb0_valid_i = 1; wb0_tag_i = 20; wb0_data_i = 32'h77;
    step();
    wb0_valid_i = 0;
    chk("ooo_wake_valid", 32'(issue_valid_o), 1);
    chk("ooo_wake_src1", issue_src1_o, 32'h77);
    step();
    chk("ooo_count", 32'(count_o), 0);
    // kill overrides dispatch and issue
    issue_ready_i = 0;
    disp(9, 30, 32'h1, 1, 32'h1, 1);
    disp(9, 31, 32'h2, 1, 32'h2, 1);
    disp(9, 32, 32'h3, 1, 32'h3, 1);
    chk("kill_pre_count", 32'(count_o), 3);
    kill_i = 1; issue_ready_i = 1;
    set_disp(9, 33, 32'h4, 1, 32'h4, 1);
    step();
    kill_i = 0; dispatch_valid_i = 0;
    chk("kill_count", 32'(count_o), 0);
    chk("kill_issue_valid", 32'(issue_valid_o), 0);
    chk("kill_dispatch_ready", 32'(dispatch_ready_o), 1);
    // reset mid-operation dominates dispatch
    issue_ready_i = 0;
    disp(9, 34, 32'h5, 1, 32'h5, 1);
    reset_i = 1;
    set_disp(9, 35, 32'h6, 1, 32'h6, 1);
    step();
    reset_i = 0; dispatch_valid_i = 0;
    chk("reset_mid_count", 32'(count_o), 0);
    chk("reset_mid_valid", 32'(issue_valid_o), 0);
    chk("reset_mid_src1", issue_src1_o, 0);
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
